// File: rtl/linear_proj_pkg.sv
// rtl/linear_proj_pkg.sv - shared state type and tile-dimension helpers for the linear projection scheduler
package linear_proj_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        FIN
    } state_t;

    function automatic int calc_k(input int inner_dim, input int block_size);
        return inner_dim / block_size;
    endfunction

    function automatic int calc_rows(input int a_outer, input int block_size,
                                     input int cores_a, input int total_input_w);
        return a_outer / (block_size * cores_a * total_input_w);
    endfunction

    function automatic int calc_cols(input int b_outer, input int block_size,
                                     input int cores_b, input int total_modules);
        return b_outer / (block_size * cores_b * total_modules);
    endfunction

    // Address width for a buffer of the given depth; a depth of one still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/linear_proj_idx_cnt.sv
// rtl/linear_proj_idx_cnt.sv - wrapping index counter used for the k, col and row loops
// Ports: clk, rst (sync active-high), clr (return to 0), inc (advance, wraps after MAX-1),
//        count_nxt (value the counter takes at the next edge), wrap (current value is MAX-1).
module linear_proj_idx_cnt
    import linear_proj_pkg::*;
#(
    parameter int MAX = 4,
    localparam int W = addr_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count_nxt,
    output logic         wrap
);

    logic [W-1:0] count;

    assign wrap = (count == W'(MAX - 1));

    // The look-ahead value lets the parent register its outputs from next-cycle indices.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc) begin
            count_nxt = wrap ? '0 : count + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/linear_proj_sched.sv
// rtl/linear_proj_sched.sv - tile scheduler issuing A/B operand beats and C write strobes
// Ports: clk, rst (sync active-high); start/busy/done run control; issue_valid/issue_ready
//        operand beat handshake with a_addr, b_addr, acc_first, acc_last; acc_valid core result
//        pulse; wr_en/wr_addr C tile write; err sticky protocol error.
// Optional: LINEAR_PROJ_PERF_CNT_EN adds stall_cnt (ready stalls plus drain wait cycles).
module linear_proj_sched
    import linear_proj_pkg::*;
#(
    parameter int A_OUTER_DIMENSION = 8,
    parameter int B_OUTER_DIMENSION = 8,
    parameter int INNER_DIMENSION   = 6,
    parameter int BLOCK_SIZE        = 2,
    parameter int NUM_CORES_A       = 2,
    parameter int NUM_CORES_B       = 1,
    parameter int TOTAL_INPUT_W     = 2,
    parameter int TOTAL_MODULES     = 4,
    localparam int K        = calc_k(INNER_DIMENSION, BLOCK_SIZE),
    localparam int ROWS     = calc_rows(A_OUTER_DIMENSION, BLOCK_SIZE, NUM_CORES_A, TOTAL_INPUT_W),
    localparam int COLS     = calc_cols(B_OUTER_DIMENSION, BLOCK_SIZE, NUM_CORES_B, TOTAL_MODULES),
    localparam int MAX_FLAG = ROWS * COLS,
    localparam int AW_A     = addr_w(ROWS * K),
    localparam int AW_B     = addr_w(COLS * K),
    localparam int AW_C     = addr_w(MAX_FLAG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [AW_A-1:0] a_addr,
    output logic [AW_B-1:0] b_addr,
    output logic            acc_first,
    output logic            acc_last,
    input  logic            acc_valid,
    output logic            wr_en,
    output logic [AW_C-1:0] wr_addr,
    output logic            err
`ifdef LINEAR_PROJ_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int KW = addr_w(K);
    localparam int CW = addr_w(COLS);
    localparam int RW = addr_w(ROWS);

    state_t state, state_nxt;

    logic [KW-1:0] k_nxt;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic          k_wrap, col_wrap, row_wrap;

    logic start_acc, transfer, write_st;

    logic            busy_n, done_n, issue_valid_n, acc_first_n, acc_last_n, wr_en_n, err_n;
    logic [AW_A-1:0] a_addr_n;
    logic [AW_B-1:0] b_addr_n;
    logic [AW_C-1:0] wr_addr_n;

    assign start_acc = (state == IDLE) && start;
    assign transfer  = (state == ISSUE) && issue_ready;
    assign write_st  = (state == WRITE);

    linear_proj_idx_cnt #(.MAX(K)) u_k_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .inc       (transfer),
        .count_nxt (k_nxt),
        .wrap      (k_wrap)
    );

    linear_proj_idx_cnt #(.MAX(COLS)) u_col_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .inc       (write_st),
        .count_nxt (col_nxt),
        .wrap      (col_wrap)
    );

    linear_proj_idx_cnt #(.MAX(ROWS)) u_row_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .inc       (write_st && col_wrap),
        .count_nxt (row_nxt),
        .wrap      (row_wrap)
    );

    // Outputs are registered from the next state and next indices, so every output
    // reflects the state it is flopped alongside and issue fields hold while stalled.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (transfer && k_wrap) state_nxt = DRAIN;
            DRAIN:   if (acc_valid) state_nxt = WRITE;
            WRITE:   state_nxt = (row_wrap && col_wrap) ? FIN : ISSUE;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_n        = (state_nxt == ISSUE) || (state_nxt == DRAIN) || (state_nxt == WRITE);
        done_n        = (state_nxt == FIN);
        issue_valid_n = (state_nxt == ISSUE);
        a_addr_n      = '0;
        b_addr_n      = '0;
        acc_first_n   = 1'b0;
        acc_last_n    = 1'b0;
        if (issue_valid_n) begin
            a_addr_n    = AW_A'(int'(row_nxt) * K + int'(k_nxt));
            b_addr_n    = AW_B'(int'(col_nxt) * K + int'(k_nxt));
            acc_first_n = (k_nxt == '0);
            acc_last_n  = (k_nxt == KW'(K - 1));
        end
        wr_en_n   = (state_nxt == WRITE);
        wr_addr_n = wr_en_n ? AW_C'(int'(row_nxt) * COLS + int'(col_nxt)) : '0;
        err_n     = (start_acc ? 1'b0 : err) | (acc_valid && (state != DRAIN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            issue_valid <= 1'b0;
            a_addr      <= '0;
            b_addr      <= '0;
            acc_first   <= 1'b0;
            acc_last    <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= busy_n;
            done        <= done_n;
            issue_valid <= issue_valid_n;
            a_addr      <= a_addr_n;
            b_addr      <= b_addr_n;
            acc_first   <= acc_first_n;
            acc_last    <= acc_last_n;
            wr_en       <= wr_en_n;
            wr_addr     <= wr_addr_n;
            err         <= err_n;
        end
    end

`ifdef LINEAR_PROJ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt <= '0;
        end else if ((((state == ISSUE) && !issue_ready) || (state == DRAIN)) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
